// File: rtl/fe_frombytes.sv
// Unpacks a 32-byte little-endian field-element encoding into ten ref10-style limbs
// (26/25-bit alternating), carry-normalised over three clock edges.
module fe_frombytes (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] in,
  input  logic         valid,
  output logic [319:0] out,
  output logic         done
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StLoad      = 3'd1;
  localparam logic [2:0] StCarryOdd  = 3'd2;
  localparam logic [2:0] StCarryEven = 3'd3;
  localparam logic [2:0] StDone      = 3'd4;

  logic [2:0]         state_q, state_d;
  logic signed [63:0] h_q [10];
  logic signed [63:0] h_d [10];
  logic signed [63:0] h_ld [10];
  logic signed [63:0] h_a [10];
  logic signed [63:0] h_b [10];
  logic signed [63:0] carry_a [10];
  logic signed [63:0] carry_b [10];
  logic [319:0]       out_q, out_d;
  logic               unused_in;

  // Bit 255 of the encoding is not part of the field element.
  assign unused_in = in[255];

  always_comb begin
    h_ld[0] = $signed({32'd0, in[31:0]});
    h_ld[1] = $signed({40'd0, in[55:32]}) <<< 6;
    h_ld[2] = $signed({40'd0, in[79:56]}) <<< 5;
    h_ld[3] = $signed({40'd0, in[103:80]}) <<< 3;
    h_ld[4] = $signed({40'd0, in[127:104]}) <<< 2;
    h_ld[5] = $signed({32'd0, in[159:128]});
    h_ld[6] = $signed({40'd0, in[183:160]}) <<< 7;
    h_ld[7] = $signed({40'd0, in[207:184]}) <<< 5;
    h_ld[8] = $signed({40'd0, in[231:208]}) <<< 4;
    h_ld[9] = $signed({41'd0, in[254:232]}) <<< 2;
  end

  // Odd (25-bit) limbs carry upward; h9 wraps into h0 scaled by 19 (2^255 = 19 mod p).
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      carry_a[i] = '0;
      h_a[i]     = h_q[i];
    end
    for (int i = 1; i < 10; i += 2) begin
      carry_a[i] = (h_q[i] + 64'sd16777216) >>> 25;
      h_a[i]     = h_q[i] - (carry_a[i] <<< 25);
    end
    h_a[0] = h_q[0] + 64'sd19 * carry_a[9];
    for (int i = 2; i < 10; i += 2) begin
      h_a[i] = h_q[i] + carry_a[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < 10; i++) begin
      carry_b[i] = '0;
      h_b[i]     = h_q[i];
    end
    for (int i = 0; i < 10; i += 2) begin
      carry_b[i] = (h_q[i] + 64'sd33554432) >>> 26;
      h_b[i]     = h_q[i] - (carry_b[i] <<< 26);
    end
    for (int i = 1; i < 10; i += 2) begin
      h_b[i] = h_q[i] + carry_b[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    for (int i = 0; i < 10; i++) begin
      h_d[i] = h_q[i];
    end
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          for (int i = 0; i < 10; i++) begin
            h_d[i] = h_ld[i];
          end
          state_d = StLoad;
        end
      end
      StLoad: begin
        for (int i = 0; i < 10; i++) begin
          h_d[i] = h_a[i];
        end
        state_d = StCarryOdd;
      end
      StCarryOdd: begin
        for (int i = 0; i < 10; i++) begin
          h_d[i]            = h_b[i];
          out_d[32*i +: 32] = h_b[i][31:0];
        end
        state_d = StCarryEven;
      end
      StCarryEven: state_d = StDone;
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      for (int i = 0; i < 10; i++) begin
        h_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      for (int i = 0; i < 10; i++) begin
        h_q[i] <= h_d[i];
      end
    end
  end

  assign out  = out_q;
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_fe_frombytes.sv
// Self-checking bench for fe_frombytes: fixed vectors, randomized inputs against a
// limb-arithmetic reference model, back-to-back start and mid-operation reset.
module tb_fe_frombytes;

  logic         clk;
  logic         rst;
  logic [255:0] din;
  logic         valid;
  logic [319:0] dout;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  fe_frombytes dut (
    .clk  (clk),
    .rst  (rst),
    .in   (din),
    .valid(valid),
    .out  (dout),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    string        name;
    logic [255:0] x;
    logic [319:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: byte loads by table, then the two carry passes on signed 64-bit integers.
  function automatic logic [319:0] model(input logic [255:0] x);
    int     off [10] = '{0, 4, 7, 10, 13, 16, 20, 23, 26, 29};
    int     len [10] = '{4, 3, 3, 3, 3, 4, 3, 3, 3, 3};
    int     sh  [10] = '{0, 6, 5, 3, 2, 0, 7, 5, 4, 2};
    longint h [10];
    longint c [10];
    logic [319:0] r;
    for (int i = 0; i < 10; i++) begin
      longint v = 0;
      for (int b = 0; b < len[i]; b++) begin
        logic [7:0] byt = x[8*(off[i]+b) +: 8];
        v = v + (longint'({56'd0, byt}) << (8*b));
      end
      if (i == 9) v = v & 64'h7fffff;
      h[i] = v << sh[i];
    end
    for (int i = 1; i < 10; i += 2) c[i] = (h[i] + 64'sd16777216) >>> 25;
    for (int i = 1; i < 10; i += 2) begin
      h[i] = h[i] - c[i] * 33554432;
      if (i == 9) h[0] = h[0] + 19 * c[i];
      else        h[i+1] = h[i+1] + c[i];
    end
    for (int i = 0; i < 10; i += 2) c[i] = (h[i] + 64'sd33554432) >>> 26;
    for (int i = 0; i < 10; i += 2) begin
      h[i]   = h[i] - c[i] * 67108864;
      h[i+1] = h[i+1] + c[i];
    end
    for (int i = 0; i < 10; i++) r[32*i +: 32] = h[i][31:0];
    return r;
  endfunction

  // Start from IDLE and check the done pulse shape, out after E2 and out held after E4.
  task automatic run_one(input string name, input logic [255:0] x, input logic [319:0] exp);
    logic [3:0]   pat;
    logic [319:0] out_e2;
    @(negedge clk);
    din   = x;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    din   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    out_e2 = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      pat[k] = done;
      if (k == 1) out_e2 = dout;
    end
    check({name, " out@E2"}, out_e2, exp);
    check({name, " done pulse"}, {316'd0, pat}, {316'd0, 4'b0100});
    check({name, " out hold"}, dout, exp);
  endtask

  initial begin
    vec_t         vecs [5];
    logic [255:0] xa, xb, xc;
    logic [319:0] tmp;
    logic [3:0]   pat;

    vecs[0] = '{"all5a", {32{8'h5a}},
      320'hff696969_01a5a5a6_ff4b4b4b_012d2d2d_005a5a5a_01696969_00d2d2d3_ff4b4b4b_00969697_fe5a5a6d};
    vecs[1] = '{"zero", 256'd0, 320'd0};
    vecs[2] = '{"one", 256'd1, 320'd1};
    vecs[3] = '{"bit255", 256'd1 << 255, 320'd0};
    vecs[4] = '{"bit25", 256'd1 << 25, {256'd0, 32'd1, 32'hfe000000}};

    rst   = 1'b0;
    valid = 1'b0;
    din   = '0;
    #22;
    check("reset out", dout, 320'd0);
    check("reset done", {319'd0, done}, 320'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_one(vecs[i].name, vecs[i].x, vecs[i].exp);

    for (int i = 0; i < 20; i++) begin
      xa = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_one("random", xa, model(xa));
    end

    // Second valid while in CARRY_ODD must be ignored.
    xa = {8{32'h89abcdef}};
    xb = {8{32'h01234567}};
    @(negedge clk);
    din   = xa;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    din   = xb;
    valid = 1'b1;
    pat   = '0;
    tmp   = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      valid = 1'b0;
      if (k < 4) pat[k] = done;
      if (k == 0) tmp = dout;
      if (k == 4) check("b2b no restart", {319'd0, done}, 320'd0);
    end
    check("b2b out first", tmp, model(xa));
    check("b2b done pulse", {316'd0, pat}, {316'd0, 4'b0010});
    check("b2b out hold", dout, model(xa));
    run_one("after b2b", xb, model(xb));

    // Reset asserted during CARRY_ODD aborts at once.
    xc = {8{32'hdeadbeef}};
    @(negedge clk);
    din   = xc;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst out", dout, 320'd0);
    check("midrst done", {319'd0, done}, 320'd0);
    pat = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      pat[k] = done;
    end
    check("midrst no pulse", {316'd0, pat}, 320'd0);
    @(negedge clk);
    rst = 1'b1;
    run_one("after rst", xc, model(xc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
